// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_pkg
//  Description : Shared widths, stall encodings, ALU op bit positions, the
//                ID-to-EX bus layout and divider state encodings for the
//                execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_RF_WD  = 38;
    localparam int STALL_BUS    = 6;
    localparam int HILO_WD      = 66;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // alu_op is one-hot; add sits in the MSB, lui in the LSB
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] FUNC_DIV  = 6'h1A;
    localparam logic [5:0] FUNC_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_to_ex_t;

    // Magnitude of a signed operand; unsigned operands pass through.
    function automatic logic [31:0] op_mag(input logic is_signed, input logic [31:0] x);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative restoring divider, one quotient bit per cycle.
//                IDLE -> RUN on start, 32 RUN steps, one DONE cycle, IDLE.
//  Ports       : clk, rst (async, active-low), start, is_signed, dividend,
//                divisor -> busy, done, quotient, remainder (valid in DONE)
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;

    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // The dividend magnitude sits in quo_q and is shifted out MSB-first into
    // the partial remainder while quotient bits are shifted in at the LSB.
    assign w_shift = {rem_q, quo_q[31]};
    assign w_diff  = w_shift - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = DIV_RUN;
                    cnt_d   = 5'd0;
                    rem_d   = 32'd0;
                    quo_d   = op_mag(is_signed, dividend);
                    dvs_d   = op_mag(is_signed, divisor);
                    // A zero divisor yields all-ones unsigned magnitude; keep
                    // it un-negated so lo reads 0xFFFFFFFF in both modes.
                    qneg_d  = is_signed && (dividend[31] ^ divisor[31]) && (divisor != 32'd0);
                    rneg_d  = is_signed && dividend[31];
                end
            end
            DIV_RUN: begin
                if (!w_diff[32]) begin
                    rem_d = w_diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = w_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign busy      = ((state_q == DIV_IDLE) && start) || (state_q == DIV_RUN);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = qneg_q ? (~quo_q + 32'd1) : quo_q;
    assign remainder = rneg_q ? (~rem_q + 32'd1) : rem_q;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage: EX pipeline register, ALU, data RAM request,
//                forwarding bus and iterative div/divu with HI/LO write.
//  Ports       : clk, rst (async, active-low), stall[5:0] (bit2 EX, bit3 MEM)
//                id_to_ex_bus in; ex_to_mem_bus, ex_to_rf_bus, data_sram_*,
//                hilo_bus {hi_we, lo_we, hi, lo}, stallreq_for_ex out
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int ID_TO_EX_WD  = ex_stage_pkg::ID_TO_EX_WD,
    parameter int EX_TO_MEM_WD = ex_stage_pkg::EX_TO_MEM_WD
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ex_stage_pkg::STALL_BUS-1:0]   stall,
    input  logic [ID_TO_EX_WD-1:0]               id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0]              ex_to_mem_bus,
    output logic [ex_stage_pkg::EX_TO_RF_WD-1:0] ex_to_rf_bus,
    output logic                                 data_sram_en,
    output logic [3:0]                           data_sram_wen,
    output logic [31:0]                          data_sram_addr,
    output logic [31:0]                          data_sram_wdata,
    output logic [ex_stage_pkg::HILO_WD-1:0]     hilo_bus,
    output logic                                 stallreq_for_ex
);
    import ex_stage_pkg::*;

    logic [ID_TO_EX_WD-1:0] ex_reg_q, ex_reg_d;
    id_to_ex_t              w_ex;

    logic [15:0] w_imm;
    logic [31:0] w_src1, w_src2, w_sra, w_alu_res;
    logic        w_slt, w_sltu;
    logic        w_is_div, w_is_divu;
    logic        w_div_busy, w_div_done;
    logic [31:0] w_quot, w_rem;

    // Bubble when EX stops but MEM moves on, capture when EX moves, else hold.
    always_comb begin
        ex_reg_d = ex_reg_q;
        if (stall[2] == STOP && stall[3] == NO_STOP) begin
            ex_reg_d = '0;
        end else if (stall[2] == NO_STOP) begin
            ex_reg_d = id_to_ex_bus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_reg_q <= '0;
        end else begin
            ex_reg_q <= ex_reg_d;
        end
    end

    assign w_ex  = ex_reg_q;
    assign w_imm = w_ex.inst[15:0];

    assign w_src1 = ({32{w_ex.sel_alu_src1[0]}} & w_ex.rdata1)
                  | ({32{w_ex.sel_alu_src1[1]}} & w_ex.pc)
                  | ({32{w_ex.sel_alu_src1[2]}} & {27'd0, w_ex.inst[10:6]});

    assign w_src2 = ({32{w_ex.sel_alu_src2[0]}} & w_ex.rdata2)
                  | ({32{w_ex.sel_alu_src2[1]}} & {{16{w_imm[15]}}, w_imm})
                  | ({32{w_ex.sel_alu_src2[2]}} & 32'd8)
                  | ({32{w_ex.sel_alu_src2[3]}} & {16'd0, w_imm});

    // Signed compare/shift kept in their own assignments so the signedness
    // is not lost to the unsigned context of the result mux.
    assign w_slt  = $signed(w_src1) < $signed(w_src2);
    assign w_sltu = w_src1 < w_src2;
    assign w_sra  = $signed(w_src2) >>> w_src1[4:0];

    always_comb begin
        w_alu_res = 32'd0;
        if (w_ex.alu_op[ALU_ADD])  w_alu_res = w_alu_res | (w_src1 + w_src2);
        if (w_ex.alu_op[ALU_SUB])  w_alu_res = w_alu_res | (w_src1 - w_src2);
        if (w_ex.alu_op[ALU_SLT])  w_alu_res = w_alu_res | {31'd0, w_slt};
        if (w_ex.alu_op[ALU_SLTU]) w_alu_res = w_alu_res | {31'd0, w_sltu};
        if (w_ex.alu_op[ALU_AND])  w_alu_res = w_alu_res | (w_src1 & w_src2);
        if (w_ex.alu_op[ALU_NOR])  w_alu_res = w_alu_res | ~(w_src1 | w_src2);
        if (w_ex.alu_op[ALU_OR])   w_alu_res = w_alu_res | (w_src1 | w_src2);
        if (w_ex.alu_op[ALU_XOR])  w_alu_res = w_alu_res | (w_src1 ^ w_src2);
        if (w_ex.alu_op[ALU_SLL])  w_alu_res = w_alu_res | (w_src2 << w_src1[4:0]);
        if (w_ex.alu_op[ALU_SRL])  w_alu_res = w_alu_res | (w_src2 >> w_src1[4:0]);
        if (w_ex.alu_op[ALU_SRA])  w_alu_res = w_alu_res | w_sra;
        if (w_ex.alu_op[ALU_LUI])  w_alu_res = w_alu_res | {w_imm, 16'd0};
    end

    assign w_is_div  = (w_ex.inst[31:26] == 6'd0) && (w_ex.inst[5:0] == FUNC_DIV);
    assign w_is_divu = (w_ex.inst[31:26] == 6'd0) && (w_ex.inst[5:0] == FUNC_DIVU);

    div_unit u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_is_div | w_is_divu),
        .is_signed (w_is_div),
        .dividend  (w_ex.rdata1),
        .divisor   (w_ex.rdata2),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_quot),
        .remainder (w_rem)
    );

    assign ex_to_mem_bus   = {w_ex.pc, w_ex.data_ram_en, w_ex.data_ram_wen, w_ex.sel_rf_res,
                              w_ex.rf_we, w_ex.rf_waddr, w_alu_res};
    assign ex_to_rf_bus    = {w_ex.rf_we, w_ex.rf_waddr, w_alu_res};
    assign data_sram_en    = w_ex.data_ram_en;
    assign data_sram_wen   = w_ex.data_ram_wen;
    assign data_sram_addr  = w_alu_res;
    assign data_sram_wdata = w_ex.rdata2;
    assign hilo_bus        = w_div_done ? {2'b11, w_rem, w_quot} : '0;
    assign stallreq_for_ex = w_div_busy;

endmodule
`default_nettype wire

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter ID_TO_EX_WD, default 159: width of the ID-to-EX bus.
REQ-002 SHALL have parameter EX_TO_MEM_WD, default 76: width of the EX-to-MEM bus.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port stall, input, 6 bits: stall vector; stall[2] is EX, stall[3] is MEM.
REQ-006 SHALL have port id_to_ex_bus, input, ID_TO_EX_WD bits: {pc, inst, alu_op[11:0], sel_alu_src1[2:0], sel_alu_src2[3:0], data_ram_en, data_ram_wen[3:0], rf_we, rf_waddr[4:0], sel_rf_res, rdata1, rdata2}.
REQ-007 SHALL have port ex_to_mem_bus, output, EX_TO_MEM_WD bits: {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}.
REQ-008 SHALL have port ex_to_rf_bus, output, 38 bits: {rf_we, rf_waddr, ex_result}, the forwarding bus to ID.
REQ-009 SHALL have port data_sram_en, output, 1 bit: data RAM enable.
REQ-010 SHALL have port data_sram_wen, output, 4 bits: data RAM byte write enables.
REQ-011 SHALL have port data_sram_addr, output, 32 bits: data RAM address.
REQ-012 SHALL have port data_sram_wdata, output, 32 bits: data RAM write data.
REQ-013 SHALL have port hilo_bus, output, 66 bits: {hi_we, lo_we, hi, lo}.
REQ-014 SHALL have port stallreq_for_ex, output, 1 bit: request to freeze IF, ID and EX.

Function
REQ-015 The EX input register SHALL be updated on each clk edge as follows:
- stall[2]=Stop and stall[3]=NoStop: load zero (bubble).
- stall[2]=NoStop: capture id_to_ex_bus.
- Otherwise: hold its value.
REQ-016 ALU operand 1 SHALL be selected one-hot: rdata1 (bit0), pc (bit1), or zero-extended inst[10:6] (bit2).
REQ-017 ALU operand 2 SHALL be selected one-hot: rdata2 (bit0), sign-extended imm (bit1), 32'd8 (bit2), or zero-extended imm (bit3).
REQ-018 alu_op SHALL be one-hot over add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- Shift amount = operand1[4:0].
- lui result = {imm, 16'b0}.
- All arithmetic is 32-bit and wraps modulo 2^32.
REQ-019 ex_result SHALL equal the ALU result, combinationally, within the same cycle.
REQ-020 Data RAM outputs SHALL be driven combinationally from the EX register:
- data_sram_en = data_ram_en.
- data_sram_wen = data_ram_wen.
- data_sram_addr = ALU result.
- data_sram_wdata = rdata2.
REQ-021 The block SHALL decode div (opcode 0, func 0x1A) and divu (func 0x1B) from inst.
REQ-022 The divider FSM SHALL have states IDLE, RUN and DONE:
- IDLE→RUN when div/divu is present in EX: latch operand magnitudes and sign flags, clear counter.
- RUN: one restoring shift-subtract step per cycle; →DONE after the 32nd step (counter=31).
- DONE→IDLE unconditionally; DONE SHALL NOT restart the divide.
REQ-023 stallreq_for_ex SHALL be 1 in the IDLE entry cycle and throughout RUN, i.e. exactly 33 cycles per divide, and 0 in DONE.
REQ-024 In DONE, hilo_bus SHALL carry hi_we=lo_we=1, lo=quotient, hi=remainder; in all other cycles hilo_bus SHALL be zero.
REQ-025 Signed divide result signs:
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-026 When the divisor is 0: lo=0xFFFFFFFF, hi=dividend; the latency SHALL be unchanged.
REQ-027 A bubble entering EX SHALL produce no side effects: rf_we=0, data_sram_en=0, hilo writes 0.

Reset
REQ-028 While rst=0, all of the following SHALL hold asynchronously:
- EX register is zero.
- FSM is IDLE and counter is 0.
- stallreq_for_ex=0.
- hilo_bus=0.
- All data_sram outputs are 0.
REQ-029 Reset asserted mid-divide SHALL abort the divide; after release no hilo write SHALL occur.

Structure
REQ-030 ID_TO_EX_WD, EX_TO_MEM_WD, StallBus, Stop/NoStop, HILO_WD=66 and the divider state encodings SHALL live in the shared lib/defines.vh.
REQ-031 The iterative divider SHALL be a sub-module named div_unit with start/signed/operands in and done/quotient/remainder out.

Verification
REQ-032 addiu: rdata1=5, imm=0xFFFF → ex_result=4, ex_to_rf_bus={1, rt, 4} in the same cycle.
REQ-033 sw: rdata1=0x1000, imm=8, rdata2=0xCAFE → data_sram_addr=0x1008, wdata=0xCAFE, wen=4'hF.
REQ-034 divu 100/7 → stallreq_for_ex high for exactly 33 cycles, then one cycle with lo=14, hi=2.
REQ-035 div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 5/0 → lo=0xFFFFFFFF, hi=5.
REQ-036 Pull rst low at RUN step 10, release it, then issue a nop → stallreq_for_ex=0 and hilo_bus stays 0.
REQ-037 stall[2]=Stop with stall[3]=NoStop → the next cycle shows a bubble (rf_we=0); stall[2:3]=Stop,Stop → the EX register holds its value.
